// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared types and constants for the multiplier job sequencer.
// Holds the FSM state encoding, the default operand width and the abort-value helper.
package mult_seq_pkg;

   localparam int DEF_DATAWIDTH = 8;
   localparam int MAX_RESULTW   = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      OUT   = 2'd3
   } seqState_t;

   // All-ones pattern of the given width (up to MAX_RESULTW bits),
   // reported as the product of an aborted job.
   function automatic logic [MAX_RESULTW-1:0] abortValue(input int width);
      logic [MAX_RESULTW-1:0] v;
      v = '0;
      for (int i = 0; i < MAX_RESULTW; i++) begin
         if (i < width) v[i] = 1'b1;
      end
      return v;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH entries of WIDTH bits, synchronous active-high reset.
// Ports: clk, Rst, push/pushData, pop/popData (head, combinational), full, empty.
module sync_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             Rst,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wrPtr;
   logic [PW-1:0]    rdPtr;
   logic [CW-1:0]    count;
   logic             doPush;
   logic             doPop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   // A full FIFO refuses pushes even when a pop frees a slot that cycle.
   assign doPush  = push && !full && !Rst;
   assign doPop   = pop && !empty;
   assign popData = mem[rdPtr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (Rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         unique case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/mult_job_sequencer.sv
// mult_job_sequencer: queues operand pairs, runs them one at a time on a
// multiplier core (start pulse + held operands), and hands back products.
// Ports: in_* operand handshake, core_* core launch/result, out_* product
// handshake with out_error, job_count (completed jobs mod 256).
// Optional macro MULT_SEQ_TIMEOUT_EN aborts a job after TIMEOUT WAIT cycles.
module mult_job_sequencer
   import mult_seq_pkg::*;
#(
   parameter int DATAWIDTH = DEF_DATAWIDTH,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 64
) (
   input  logic                   clk,
   input  logic                   Rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [DATAWIDTH-1:0]   in_a,
   input  logic [DATAWIDTH-1:0]   in_b,
   output logic                   core_start,
   output logic [DATAWIDTH-1:0]   core_opA,
   output logic [DATAWIDTH-1:0]   core_opB,
   input  logic                   core_done,
   input  logic [2*DATAWIDTH-1:0] core_result,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*DATAWIDTH-1:0] out_result,
   output logic                   out_error,
   output logic [7:0]             job_count
);

   localparam int RW = 2 * DATAWIDTH;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : gBadDepth
      $error("DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT < 1) begin : gBadTimeout
      $error("TIMEOUT must be >= 1");
   end

   seqState_t            state;
   seqState_t            nextState;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic                 pushReq;
   logic                 popReq;
   logic [RW-1:0]        fifoData;
   logic [DATAWIDTH-1:0] opA;
   logic [DATAWIDTH-1:0] opB;
   logic [RW-1:0]        resultQ;
   logic [7:0]           jobCount;
   logic                 capture;
   logic                 accept;

   assign in_ready = !fifoFull && !Rst;
   assign pushReq  = in_valid && in_ready;

   sync_fifo #(
      .WIDTH (RW),
      .DEPTH (DEPTH)
   ) uFifo (
      .clk      (clk),
      .Rst      (Rst),
      .push     (pushReq),
      .pushData ({in_a, in_b}),
      .pop      (popReq),
      .popData  (fifoData),
      .full     (fifoFull),
      .empty    (fifoEmpty)
   );

`ifdef MULT_SEQ_TIMEOUT_EN
   localparam int             TCW       = $clog2(TIMEOUT + 1);
   localparam logic [TCW-1:0] LAST      = TCW'(TIMEOUT - 1);
   localparam logic [RW-1:0]  ABORT_VAL = RW'(abortValue(RW));

   logic [TCW-1:0] waitCnt;
   logic           abortNow;
   logic           errorQ;

   // A done arriving on the final WAIT edge takes priority over the abort.
   assign abortNow = (state == WAIT) && !core_done && (waitCnt == LAST);

   always_ff @(posedge clk) begin
      if (Rst) begin
         waitCnt <= '0;
      end else if (state == START) begin
         waitCnt <= '0;
      end else if ((state == WAIT) && !core_done && (waitCnt != LAST)) begin
         waitCnt <= waitCnt + TCW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (Rst) begin
         errorQ <= 1'b0;
      end else if (capture) begin
         errorQ <= 1'b0;
      end else if (abortNow) begin
         errorQ <= 1'b1;
      end
   end

   assign out_error = errorQ;
`else
   assign out_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (Rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      popReq    = 1'b0;
      capture   = 1'b0;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifoEmpty) begin
               popReq    = 1'b1;
               nextState = START;
            end
         end
         START: nextState = WAIT;
         WAIT: begin
            if (core_done) begin
               capture   = 1'b1;
               nextState = OUT;
            end
`ifdef MULT_SEQ_TIMEOUT_EN
            if (abortNow) nextState = OUT;
`endif
         end
         OUT: begin
            if (out_ready) begin
               accept    = 1'b1;
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Operands change only on pop, so the core sees them stable from
   // START until the next job is dequeued.
   always_ff @(posedge clk) begin
      if (Rst) begin
         opA      <= '0;
         opB      <= '0;
         resultQ  <= '0;
         jobCount <= '0;
      end else begin
         if (popReq) {opA, opB} <= fifoData;
         if (capture) resultQ <= core_result;
`ifdef MULT_SEQ_TIMEOUT_EN
         else if (abortNow) resultQ <= ABORT_VAL;
`endif
         if (accept) jobCount <= jobCount + 8'd1;
      end
   end

   assign core_start = (state == START);
   assign core_opA   = opA;
   assign core_opB   = opB;
   assign out_valid  = (state == OUT);
   assign out_result = resultQ;
   assign job_count  = jobCount;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// tb_mult_job_sequencer: directed self-checking bench for mult_job_sequencer.
// Acts as the multiplier core (done after a chosen delay) and the consumer.
module tb_mult_job_sequencer;

   logic        clk = 1'b0;
   logic        Rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        core_start;
   logic [7:0]  core_opA;
   logic [7:0]  core_opB;
   logic        core_done;
   logic [15:0] core_result;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_error;
   logic [7:0]  job_count;

   int vecCount  = 0;
   int missCount = 0;

   logic [7:0]  fa [5] = '{8'd1, 8'd3, 8'd10, 8'd255, 8'd16};
   logic [7:0]  fb [5] = '{8'd2, 8'd4, 8'd10, 8'd1, 8'd16};
   logic [15:0] fp [5] = '{16'd2, 16'd12, 16'd100, 16'd255, 16'd256};

   mult_job_sequencer #(
      .DATAWIDTH (8),
      .DEPTH     (4),
      .TIMEOUT   (64)
   ) dut (
      .clk         (clk),
      .Rst         (Rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .core_start  (core_start),
      .core_opA    (core_opA),
      .core_opB    (core_opB),
      .core_done   (core_done),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_error   (out_error),
      .job_count   (job_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      vecCount++;
      if (got !== exp) begin
         missCount++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      tick();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for the start pulse, then step into WAIT.
   task automatic launch(input string tag);
      int n = 0;
      while (!core_start && n < 50) begin
         tick();
         n++;
      end
      chk(tag, 32'(core_start), 32'd1);
      tick();
   endtask

   // Core model: done after lat WAIT cycles with the true product.
   task automatic finish(input int lat, input logic [15:0] exp,
                         input string tag);
      repeat (lat) tick();
      core_done   = 1'b1;
      core_result = 16'(core_opA) * 16'(core_opB);
      tick();
      core_done   = 1'b0;
      core_result = '0;
      chk({tag, ".valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".result"}, 32'(out_result), 32'(exp));
      chk({tag, ".error"}, 32'(out_error), 32'd0);
   endtask

   task automatic accept();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      logic sawStart;
      Rst         = 1'b1;
      in_valid    = 1'b0;
      in_a        = '0;
      in_b        = '0;
      core_done   = 1'b0;
      core_result = '0;
      out_ready   = 1'b0;
      tick();
      tick();
      chk("rst.inReady", 32'(in_ready), 32'd0);
      chk("rst.start", 32'(core_start), 32'd0);
      chk("rst.valid", 32'(out_valid), 32'd0);
      chk("rst.result", 32'(out_result), 32'd0);
      chk("rst.error", 32'(out_error), 32'd0);
      chk("rst.jobs", 32'(job_count), 32'd0);
      Rst = 1'b0;
      #1;
      chk("rst.inReadyRel", 32'(in_ready), 32'd1);

      // single job 7*6
      push(8'd7, 8'd6);
      chk("one.noStartYet", 32'(core_start), 32'd0);
      tick();
      chk("one.start", 32'(core_start), 32'd1);
      chk("one.opA", 32'(core_opA), 32'd7);
      chk("one.opB", 32'(core_opB), 32'd6);
      tick();
      chk("one.startPulse", 32'(core_start), 32'd0);
      finish(20, 16'h002A, "one");
      chk("one.jobsBefore", 32'(job_count), 32'd0);
      accept();
      chk("one.validDrop", 32'(out_valid), 32'd0);
      chk("one.jobs", 32'(job_count), 32'd1);

      // spurious done in IDLE and START
      core_done   = 1'b1;
      core_result = 16'hDEAD;
      tick();
      tick();
      chk("spur.idle", 32'(out_valid), 32'd0);
      push(8'd3, 8'd5);
      tick();
      chk("spur.start", 32'(core_start), 32'd1);
      tick();
      core_done   = 1'b0;
      core_result = '0;
      chk("spur.noOut", 32'(out_valid), 32'd0);
      chk("spur.held", 32'(out_result), 32'h002A);
      finish(3, 16'h000F, "spur");
      accept();
      chk("spur.jobs", 32'(job_count), 32'd2);

      // fill the FIFO while the core stalls
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_a     = fa[i];
         in_b     = fb[i];
         #0;
         chk($sformatf("fill.acc%0d", i), 32'(in_ready), 32'd1);
         tick();
      end
      in_a = 8'd9;
      in_b = 8'd9;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("fill.stall%0d", i), 32'(in_ready), 32'd0);
         tick();
      end
      in_valid = 1'b0;
      finish(2, fp[0], "fill0");
      accept();
      for (int j = 1; j < 5; j++) begin
         launch($sformatf("fill%0d.launch", j));
         finish(1, fp[j], $sformatf("fill%0d", j));
         accept();
      end
      sawStart = 1'b0;
      repeat (5) begin
         tick();
         sawStart |= core_start;
      end
      chk("fill.drained", 32'(sawStart), 32'd0);
      chk("fill.jobs", 32'(job_count), 32'd7);

      // backpressure on 255*255
      push(8'd255, 8'd255);
      launch("bp.launch");
      finish(4, 16'hFE01, "bp");
      in_valid = 1'b1;
      in_a     = 8'd2;
      in_b     = 8'd3;
      for (int i = 0; i < 10; i++) begin
         tick();
         in_valid = 1'b0;
         chk($sformatf("bp.valid%0d", i), 32'(out_valid), 32'd1);
         chk($sformatf("bp.result%0d", i), 32'(out_result), 32'hFE01);
         chk($sformatf("bp.noStart%0d", i), 32'(core_start), 32'd0);
      end
      accept();
      launch("bp2.launch");
      finish(1, 16'd6, "bp2");
      accept();
      chk("bp.jobs", 32'(job_count), 32'd9);

      // reset mid-job with two entries queued
      push(8'd1, 8'd1);
      push(8'd2, 8'd2);
      push(8'd3, 8'd3);
      Rst = 1'b1;
      tick();
      chk("mid.inReady", 32'(in_ready), 32'd0);
      chk("mid.valid", 32'(out_valid), 32'd0);
      chk("mid.result", 32'(out_result), 32'd0);
      chk("mid.opA", 32'(core_opA), 32'd0);
      chk("mid.opB", 32'(core_opB), 32'd0);
      chk("mid.jobs", 32'(job_count), 32'd0);
      chk("mid.start", 32'(core_start), 32'd0);
      Rst = 1'b0;
      sawStart = 1'b0;
      repeat (8) begin
         tick();
         sawStart |= core_start;
      end
      chk("mid.noStart", 32'(sawStart), 32'd0);
      chk("mid.empty", 32'(in_ready), 32'd1);

`ifdef MULT_SEQ_TIMEOUT_EN
      push(8'd9, 8'd9);
      launch("to.launch");
      repeat (63) tick();
      chk("to.notYet", 32'(out_valid), 32'd0);
      tick();
      chk("to.valid", 32'(out_valid), 32'd1);
      chk("to.result", 32'(out_result), 32'hFFFF);
      chk("to.error", 32'(out_error), 32'd1);
      accept();
      chk("to.jobs", 32'(job_count), 32'd1);
      push(8'd2, 8'd5);
      launch("toLast.launch");
      finish(63, 16'd10, "toLast");
      accept();
      chk("toLast.jobs", 32'(job_count), 32'd2);
`else
      push(8'd9, 8'd9);
      launch("long.launch");
      repeat (100) tick();
      chk("long.noAbort", 32'(out_valid), 32'd0);
      finish(0, 16'd81, "long");
      accept();
      chk("long.jobs", 32'(job_count), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vecCount, missCount);
      $finish;
   end

endmodule
